// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared state encodings, lsb_size codes, IO decode constants and byte-count helper
package mem_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, LOAD, STORE} state_t;
  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;
  localparam int IO_HI = 17;
  localparam int IO_LO = 16;
  localparam logic [1:0] IO_SEL = 2'b11;
  function automatic logic [2:0] size_bytes(input logic [1:0] s);
    return s == SIZE_B ? 3'd1 : s == SIZE_H ? 3'd2 : 3'd4;
  endfunction
endpackage

// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial RAM controller for fetch (if_*) and load/store (lsb_*) with rdy freeze, rollback, IO stall; ports clk rst rdy mem_din/mem_dout/mem_a/mem_wr io_buffer_full if_en/if_pc/if_done/if_data lsb_en/lsb_wr/lsb_addr/lsb_size/lsb_signed/lsb_w_data/lsb_done/lsb_r_data rollback
module mem_ctrl
  import mem_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full,
  input  logic        if_en,
  input  logic [31:0] if_pc,
  output logic        if_done,
  output logic [31:0] if_data,
  input  logic        lsb_en,
  input  logic        lsb_wr,
  input  logic [31:0] lsb_addr,
  input  logic [1:0]  lsb_size,
  input  logic        lsb_signed,
  input  logic [31:0] lsb_w_data,
  output logic        lsb_done,
  output logic [31:0] lsb_r_data,
  input  logic        rollback
);
  state_t state;
  logic [2:0] cnt, n, cnt1, rd_cnt;
  logic v, sgn, nxt_v, stall, s;
  logic [31:0] addr, wd, pidx, nidx, rd_word;
  logic [23:0] rbuf;
  logic [7:0] dout_q;
  always_comb begin
    cnt1 = cnt + 3'd1;
    rd_cnt = v ? cnt1 : cnt;
    pidx = mem_a - addr;
    nxt_v = pidx == {29'd0, rd_cnt} && pidx < {29'd0, n};
    nidx = nxt_v ? pidx + 32'd1 : {29'd0, rd_cnt};
    s = sgn & mem_din[7];
    rd_word = n == 3'd1 ? {{24{s}}, mem_din} : n == 3'd2 ? {{16{s}}, mem_din, rbuf[7:0]} : {mem_din, rbuf[23:0]};
    stall = mem_a[IO_HI:IO_LO] == IO_SEL && io_buffer_full;
    mem_wr = state == STORE && rdy && !stall;
    mem_dout = mem_wr ? dout_q : 8'd0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      n <= '0;
      v <= 1'b0;
      sgn <= 1'b0;
      addr <= '0;
      wd <= '0;
      rbuf <= '0;
      dout_q <= '0;
      mem_a <= '0;
      if_done <= 1'b0;
      lsb_done <= 1'b0;
      if_data <= '0;
      lsb_r_data <= '0;
    end else if (rdy) begin
      if_done <= 1'b0;
      lsb_done <= 1'b0;
      case (state)
        IDLE: if (!rollback && !if_done && !lsb_done) begin
          cnt <= '0;
          v <= 1'b0;
          if (lsb_en) begin
            state <= lsb_wr ? STORE : LOAD;
            addr <= lsb_addr;
            mem_a <= lsb_addr;
            n <= size_bytes(lsb_size);
            sgn <= lsb_signed;
            wd <= lsb_w_data;
            dout_q <= lsb_w_data[7:0];
          end else if (if_en) begin
            state <= FETCH;
            addr <= if_pc;
            mem_a <= if_pc;
            n <= 3'd4;
            sgn <= 1'b0;
          end
        end
        FETCH, LOAD: if (rollback || (state == FETCH && !if_en)) begin
          state <= IDLE;
          mem_a <= '0;
        end else if (v && cnt1 == n) begin
          state <= IDLE;
          mem_a <= '0;
          if (state == FETCH) begin
            if_done <= 1'b1;
            if_data <= rd_word;
          end else begin
            lsb_done <= 1'b1;
            lsb_r_data <= rd_word;
          end
        end else begin
          if (v) rbuf[{cnt[1:0], 3'b000} +: 8] <= mem_din;
          cnt <= rd_cnt;
          v <= nxt_v;
          // reissue the oldest missing byte when the in-flight one was lost to a pause
          mem_a <= addr + nidx;
        end
        STORE: if (!stall) begin
          if (cnt1 == n) begin
            state <= IDLE;
            lsb_done <= 1'b1;
            mem_a <= '0;
            dout_q <= '0;
          end else begin
            cnt <= cnt1;
            mem_a <= addr + {29'd0, cnt1};
            dout_q <= wd[{cnt1[1:0], 3'b000} +: 8];
          end
        end
        default: state <= IDLE;
      endcase
    end else begin
      // a paused cycle discards whatever byte was arriving on mem_din
      v <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed and randomized self-checking bench for mem_ctrl against a byte-array memory model
module tb_mem_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rdy = 1'b1;
  logic [7:0] mem_din = 8'd0;
  logic [7:0] mem_dout;
  logic [31:0] mem_a;
  logic mem_wr;
  logic io_buffer_full = 1'b0;
  logic if_en = 1'b0;
  logic [31:0] if_pc = '0;
  logic if_done;
  logic [31:0] if_data;
  logic lsb_en = 1'b0;
  logic lsb_wr = 1'b0;
  logic [31:0] lsb_addr = '0;
  logic [1:0] lsb_size = '0;
  logic lsb_signed = 1'b0;
  logic [31:0] lsb_w_data = '0;
  logic lsb_done;
  logic [31:0] lsb_r_data;
  logic rollback = 1'b0;
  logic poke_en = 1'b0;
  logic [31:0] poke_a = '0;
  logic [7:0] poke_d = '0;
  logic [7:0] ram [0:262143];
  logic [7:0] mdl [0:262143];
  int wr_cnt = 0;
  int checks = 0;
  int errors = 0;

  mem_ctrl dut (
    .clk(clk), .rst(rst), .rdy(rdy), .mem_din(mem_din), .mem_dout(mem_dout),
    .mem_a(mem_a), .mem_wr(mem_wr), .io_buffer_full(io_buffer_full),
    .if_en(if_en), .if_pc(if_pc), .if_done(if_done), .if_data(if_data),
    .lsb_en(lsb_en), .lsb_wr(lsb_wr), .lsb_addr(lsb_addr), .lsb_size(lsb_size),
    .lsb_signed(lsb_signed), .lsb_w_data(lsb_w_data), .lsb_done(lsb_done),
    .lsb_r_data(lsb_r_data), .rollback(rollback)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    mem_din <= ram[mem_a[17:0]];
    if (mem_wr) begin
      ram[mem_a[17:0]] <= mem_dout;
      wr_cnt <= wr_cnt + 1;
    end
    if (poke_en) ram[poke_a[17:0]] <= poke_d;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [31:0] a, input logic [7:0] d);
    poke_en = 1'b1;
    poke_a = a;
    poke_d = d;
    mdl[a[17:0]] = d;
    step();
    poke_en = 1'b0;
  endtask

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] sz, input logic sg);
    int nb;
    logic [31:0] r, ak;
    nb = sz == 2'b00 ? 1 : sz == 2'b01 ? 2 : 4;
    r = '0;
    for (int k = 0; k < nb; k++) begin
      ak = a + k;
      r = r | ({24'd0, mdl[ak[17:0]]} << (8 * k));
    end
    if (sg && nb < 4 && r[8 * nb - 1]) r = r | (32'hFFFF_FFFF << (8 * nb));
    return r;
  endfunction

  // kind: 0 fetch, 1 load, 2 store; exp_lat < 0 skips the latency check
  task automatic xact(input string tag, input int kind, input logic [31:0] a, input logic [1:0] sz,
                      input logic sg, input logic [31:0] wd, input bit rnd, input int exp_lat);
    int nb, lat, w0;
    logic got, pulse;
    logic [31:0] data, exp, ak;
    nb = kind == 0 ? 4 : (sz == 2'b00 ? 1 : sz == 2'b01 ? 2 : 4);
    exp = kind == 2 ? 32'd0 : ref_load(a, kind == 0 ? 2'b10 : sz, kind == 1 && sg);
    w0 = wr_cnt;
    lat = 0;
    got = 1'b0;
    data = '0;
    if (kind == 0) begin
      if_en = 1'b1;
      if_pc = a;
    end else begin
      lsb_en = 1'b1;
      lsb_wr = kind == 2;
      lsb_addr = a;
      lsb_size = sz;
      lsb_signed = sg;
      lsb_w_data = wd;
    end
    for (int i = 0; i < 200 && !got; i++) begin
      step();
      lat++;
      got = kind == 0 ? if_done : lsb_done;
      if (got) data = kind == 0 ? if_data : lsb_r_data;
      else if (rnd) rdy = $urandom_range(0, 3) != 0;
    end
    rdy = 1'b1;
    if_en = 1'b0;
    lsb_en = 1'b0;
    chk({tag, " done"}, {31'd0, got}, 32'd1);
    if (exp_lat >= 0) chk({tag, " latency"}, lat, exp_lat);
    if (kind != 2) chk({tag, " data"}, data, exp);
    step();
    pulse = kind == 0 ? if_done : lsb_done;
    chk({tag, " single pulse"}, {31'd0, pulse}, 32'd0);
    chk({tag, " write count"}, wr_cnt - w0, kind == 2 ? nb : 0);
    if (kind == 2)
      for (int k = 0; k < nb; k++) begin
        ak = a + k;
        mdl[ak[17:0]] = wd[8 * k +: 8];
        chk({tag, " ram byte"}, {24'd0, ram[ak[17:0]]}, {24'd0, wd[8 * k +: 8]});
      end
  endtask

  initial begin
    int lat, w0, hits, kind;
    logic [31:0] a;
    logic [1:0] sz;
    logic got;
    poke(32'h100, 8'h13);
    poke(32'h101, 8'h05);
    poke(32'h102, 8'h00);
    poke(32'h103, 8'h00);
    poke(32'h20, 8'h80);
    poke(32'h21, 8'h9A);
    poke(32'hFFFF_FFFE, 8'hAA);
    poke(32'hFFFF_FFFF, 8'hBB);
    poke(32'h0, 8'hCC);
    poke(32'h1, 8'hDD);
    for (int i = 0; i < 64; i++) poke(32'h1000 + i, 8'($urandom));
    chk("rst mem_a", mem_a, 0);
    chk("rst mem_dout", {24'd0, mem_dout}, 0);
    chk("rst mem_wr", {31'd0, mem_wr}, 0);
    chk("rst if_done", {31'd0, if_done}, 0);
    chk("rst lsb_done", {31'd0, lsb_done}, 0);
    chk("rst if_data", if_data, 0);
    chk("rst lsb_r_data", lsb_r_data, 0);
    rst = 1'b0;
    step();

    xact("fetch", 0, 32'h100, 2'b10, 1'b0, 0, 0, 6);
    chk("fetch word", if_data, 32'h0000_0513);
    xact("lb signed", 1, 32'h20, 2'b00, 1'b1, 0, 0, 3);
    chk("lb signed value", lsb_r_data, 32'hFFFF_FF80);
    xact("lb unsigned", 1, 32'h20, 2'b00, 1'b0, 0, 0, 3);
    chk("lb unsigned value", lsb_r_data, 32'h0000_0080);
    xact("lh signed", 1, 32'h20, 2'b01, 1'b1, 0, 0, 4);
    xact("lh unsigned", 1, 32'h20, 2'b01, 1'b0, 0, 0, 4);
    xact("size 11 word", 1, 32'h100, 2'b11, 1'b1, 0, 0, 6);
    xact("wrap word", 1, 32'hFFFF_FFFE, 2'b10, 1'b0, 0, 0, 6);
    chk("wrap value", lsb_r_data, 32'hDDCC_BBAA);

    lsb_en = 1'b1; lsb_wr = 1'b1; lsb_addr = 32'h40; lsb_size = 2'b10; lsb_w_data = 32'hDEAD_BEEF;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("sw mem_wr", {31'd0, mem_wr}, 1);
      chk("sw mem_a", mem_a, 32'h40 + k);
      chk("sw mem_dout", {24'd0, mem_dout}, {24'd0, lsb_w_data[8 * k +: 8]});
      chk("sw early done", {31'd0, lsb_done}, 0);
    end
    step();
    chk("sw done", {31'd0, lsb_done}, 1);
    chk("sw idle mem_wr", {31'd0, mem_wr}, 0);
    lsb_en = 1'b0;
    for (int k = 0; k < 4; k++) mdl[18'h40 + k] = lsb_w_data[8 * k +: 8];
    step();

    lsb_en = 1'b1; lsb_wr = 1'b0; lsb_addr = 32'h20; lsb_size = 2'b00; lsb_signed = 1'b0;
    if_en = 1'b1; if_pc = 32'h100;
    lat = 0; got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      step();
      lat++;
      got = lsb_done;
    end
    chk("arb load first", lat, 3);
    chk("arb load data", lsb_r_data, 32'h80);
    chk("arb no fetch", {31'd0, if_done}, 0);
    lsb_en = 1'b0;
    step();
    chk("arb idle after done", mem_a, 0);
    step();
    chk("arb fetch starts", mem_a, 32'h100);
    step();
    rollback = 1'b1;
    step();
    rollback = 1'b0;
    chk("rollback idle", mem_a, 0);
    if_en = 1'b0;
    hits = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      hits += int'(if_done);
    end
    chk("rollback no if_done", hits, 0);

    if_en = 1'b1; if_pc = 32'h100;
    step(); step(); step();
    if_en = 1'b0;
    step();
    chk("if_en abort idle", mem_a, 0);
    hits = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      hits += int'(if_done) + int'(mem_wr);
    end
    chk("if_en abort quiet", hits, 0);

    w0 = wr_cnt;
    lsb_en = 1'b1; lsb_wr = 1'b1; lsb_addr = 32'h30000; lsb_size = 2'b00; lsb_w_data = 32'h41;
    io_buffer_full = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("io stalled", {31'd0, mem_wr}, 0);
    end
    step();
    io_buffer_full = 1'b0;
    #1;
    chk("io write", {31'd0, mem_wr}, 1);
    chk("io data", {24'd0, mem_dout}, 32'h41);
    chk("io addr", mem_a, 32'h30000);
    step();
    chk("io done", {31'd0, lsb_done}, 1);
    lsb_en = 1'b0;
    step();
    chk("io one write", wr_cnt - w0, 1);

    if_en = 1'b1; if_pc = 32'h100;
    step();
    rdy = 1'b0;
    step();
    step();
    rdy = 1'b1;
    lat = 3; got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      step();
      lat++;
      got = if_done;
    end
    chk("freeze done delay", lat, 8);
    chk("freeze data", if_data, 32'h0000_0513);
    if_en = 1'b0;
    step();

    w0 = wr_cnt;
    lsb_en = 1'b1; lsb_wr = 1'b1; lsb_addr = 32'h50; lsb_size = 2'b10; lsb_w_data = 32'h1122_3344;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    lsb_en = 1'b0;
    chk("rst store mem_wr", {31'd0, mem_wr}, 0);
    hits = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      hits += int'(lsb_done) + int'(mem_wr);
    end
    chk("rst store quiet", hits, 0);
    chk("rst store writes", wr_cnt - w0, 2);
    mdl[18'h50] = 8'h44;
    mdl[18'h51] = 8'h33;

    for (int t = 0; t < 60; t++) begin
      kind = $urandom_range(0, 2);
      sz = 2'($urandom);
      a = 32'h1000 + $urandom_range(0, 60);
      xact("rand", kind, a, sz, 1'($urandom), $urandom, 1, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 rst  input  1  synchronous, active-high reset.
REQ-003 rdy  input  1  global enable; low freezes all state.
REQ-004 mem_din  input  8  RAM read byte, valid 1 cycle after its address.
REQ-005 mem_dout  output  8  RAM write byte.
REQ-006 mem_a  output  32  RAM byte address.
REQ-007 mem_wr  output  1  1 = write the mem_dout byte at mem_a.
REQ-008 io_buffer_full  input  1  UART buffer full; stalls IO writes.
REQ-009 if_en  input  1  fetch request, held high until if_done.
REQ-010 if_pc  input  32  fetch address, stable while if_en is high.
REQ-011 if_done  output  1  one-cycle pulse; if_data valid.
REQ-012 if_data  output  32  fetched word, little-endian.
REQ-013 lsb_en  input  1  load/store request, held high until lsb_done.
REQ-014 lsb_wr  input  1  1 = store, 0 = load.
REQ-015 lsb_addr  input  32  byte address.
REQ-016 lsb_size  input  2  00 byte, 01 half, 10 word; 11 is illegal and treated as word.
REQ-017 lsb_signed  input  1  load sign-extends when 1, zero-extends when 0.
REQ-018 lsb_w_data  input  32  store data; low n bytes used.
REQ-019 lsb_done  output  1  one-cycle completion pulse.
REQ-020 lsb_r_data  output  32  extended load result.
REQ-021 rollback  input  1  misprediction flush from the ROB.

Function
REQ-022 States: IDLE, FETCH, LOAD, STORE; a 3-bit byte counter; one request in service at a time.
REQ-023 In IDLE the block samples requests each rdy cycle; lsb_en takes priority over if_en when both are high.
REQ-024 Acceptance in cycle N latches address, size and data.
- Read of n bytes: mem_a = addr+k in cycle N+1+k, for k = 0..n-1.
- Byte k is captured from mem_din in cycle N+2+k.
- done and data are registered high in cycle N+n+2: word fetch in N+6, byte load in N+3.
REQ-025 Store of n bytes: mem_wr=1, mem_a=addr+k and mem_dout=w_data[8k+7:8k] in cycle N+1+k; lsb_done is high in cycle N+n+1.
REQ-026 IO store: when addr[17:16]==2'b11 and io_buffer_full=1, the byte is not written (mem_wr=0) and the counter holds until io_buffer_full falls.
REQ-027 Bytes are assembled little-endian: byte 0 goes to bits [7:0].
REQ-028 Load extension:
- Bits above 8n are filled with bit 8n-1 when lsb_signed=1, otherwise with 0.
- A word load is passed through unchanged.
REQ-029 if_done and lsb_done are single-cycle pulses; the state returns to IDLE in the same cycle as the pulse.
REQ-030 The next request is sampled no earlier than the cycle after a done pulse, so a requester that drops en on done is never re-served.
REQ-031 if_en falling during FETCH aborts the fetch:
- state goes to IDLE next cycle;
- no if_done is issued;
- mem_wr stays 0.
REQ-032 rollback=1 during FETCH or LOAD aborts the read to IDLE with no done pulse.
REQ-033 rollback is ignored during STORE; a committed store always completes.
REQ-034 rollback has priority over acceptance in IDLE.
REQ-035 Behaviour while rdy=0:
- state, counter and outputs hold, except mem_wr, which is forced to 0;
- any mem_din byte whose capture slot falls in a paused cycle is discarded;
- that byte's address is reissued on resume.
REQ-036 Outside STORE write cycles, mem_wr=0 and mem_dout=0; in IDLE, mem_a=0.
REQ-037 Address arithmetic is 32-bit modulo; addr+k wraps from 0xFFFFFFFF to 0.

Reset
REQ-038 On rst=1:
- state=IDLE and counter=0;
- mem_a=0, mem_dout=0, mem_wr=0;
- if_done=0, lsb_done=0, if_data=0, lsb_r_data=0.
REQ-039 rst mid-operation abandons the request within one cycle, with no done pulse and no further RAM writes.
REQ-040 rst takes precedence over rdy and rollback.

Structure
REQ-041 A shared header holds:
- state encodings;
- lsb_size codes;
- IO address decode constants (bits [17:16]==2'b11).
REQ-042 The block is a single module with no sub-module; byte assembly and extension are inline logic.

Verification
REQ-043 Fetch: RAM[0x100..0x103]=13 05 00 00; if_en=1, if_pc=0x100 accepted in cycle N -> if_done in N+6, if_data=0x00000513, one pulse only.
REQ-044 Signed byte load: RAM[0x20]=0x80; lsb_en=1, lsb_size=00, lsb_signed=1 -> lsb_done in N+3, lsb_r_data=0xFFFFFF80; the same access with lsb_signed=0 -> 0x00000080.
REQ-045 Word store: lsb_wr=1, lsb_addr=0x40, lsb_w_data=0xDEADBEEF -> cycles N+1..N+4 show (0x40,EF), (0x41,BE), (0x42,AD), (0x43,DE) with mem_wr=1; lsb_done in N+5.
REQ-046 Arbitration and abort, both requests raised in the same cycle:
- the load is served first; the fetch starts the cycle after lsb_done;
- rollback in FETCH cycle N+2 -> no if_done, IDLE next cycle.
REQ-047 IO stall: store byte 0x41 to 0x30000 with io_buffer_full=1 for 3 cycles -> mem_wr=0 for those cycles, then one write of 0x41; lsb_done follows.
REQ-048 Freeze and reset: rdy=0 for 2 cycles mid word fetch -> if_data is still correct, with done delayed by 2 cycles; rst during a store -> mem_wr=0 next cycle and no lsb_done.
